// File: rtl/sd_image_arbiter.sv
// ---------------------------------------------------------------------------
// sd_image_arbiter
//
// Multi-drive SD image arbiter between the user_io SD block-transfer port and
// up to eight disk controllers. One drive is granted at a time, chosen
// round-robin starting after the last drive served. The granted drive's LBA
// and read/write request are presented to user_io, and sector-buffer traffic
// is steered to and from that drive only. Each request has a timeout while
// waiting for sd_ack, and each drive receives one-cycle done/error pulses.
//
// Ports
//   clk_sys         system clock
//   reset_n         asynchronous active-low reset
//   drv_lba         per-drive LBA, drive i at [i*LBA_W +: LBA_W]
//   drv_rd/drv_wr   per-drive read/write request levels
//   drv_din         per-drive write-buffer byte, drive i at [i*8 +: 8]
//   drv_ack         per-drive transfer-active level (one-hot or zero)
//   drv_buff_wr     per-drive read-data strobe
//   drv_done        one-cycle pulse on successful completion
//   drv_err         one-cycle pulse on timeout
//   sd_lba          LBA presented to user_io
//   sd_rd/sd_wr     request per image slot to user_io
//   sd_ack          transfer active, from user_io
//   sd_buff_addr    byte index within sector (routed to drives externally)
//   sd_dout_strobe  read byte valid from user_io
//   sd_din          write byte to user_io
//   busy            high whenever a request is in flight
// ---------------------------------------------------------------------------
module sd_image_arbiter #(
   parameter int          NUM_DRIVES = 2,
   parameter int          LBA_W      = 32,
   parameter logic [23:0] TIMEOUT    = 24'd8_000_000
) (
   input  logic                          clk_sys,
   input  logic                          reset_n,
   input  logic [NUM_DRIVES*LBA_W-1:0]   drv_lba,
   input  logic [NUM_DRIVES-1:0]         drv_rd,
   input  logic [NUM_DRIVES-1:0]         drv_wr,
   input  logic [NUM_DRIVES*8-1:0]       drv_din,
   output logic [NUM_DRIVES-1:0]         drv_ack,
   output logic [NUM_DRIVES-1:0]         drv_buff_wr,
   output logic [NUM_DRIVES-1:0]         drv_done,
   output logic [NUM_DRIVES-1:0]         drv_err,
   output logic [LBA_W-1:0]              sd_lba,
   output logic [NUM_DRIVES-1:0]         sd_rd,
   output logic [NUM_DRIVES-1:0]         sd_wr,
   input  logic                          sd_ack,
   input  logic [8:0]                    sd_buff_addr,
   input  logic                          sd_dout_strobe,
   output logic [7:0]                    sd_din,
   output logic                          busy
);

   localparam int IDX_W = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_XFER = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]            state;
   logic [IDX_W-1:0]      grant;
   logic [IDX_W-1:0]      last;
   logic                  op_wr;
   logic [23:0]           tmo_cnt;

   logic [NUM_DRIVES-1:0] pending;
   logic [NUM_DRIVES-1:0] grant_oh;
   logic                  pick_vld;
   logic [IDX_W-1:0]      pick_idx;
   logic                  tmo_hit;
   logic                  in_req;
   logic                  in_xfer;

   // The sector byte address is consumed by the drives directly.
   logic                  unused_buff_addr;
   assign unused_buff_addr = ^sd_buff_addr;

   assign pending = drv_rd | drv_wr;

   // Round-robin pick: scan offsets last+1 .. last+NUM_DRIVES (mod N).
   // Walking the offsets from farthest to nearest lets the nearest pending
   // drive overwrite any earlier hit, so no early exit is needed.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int k = NUM_DRIVES; k >= 1; k--) begin
         if (pending[(int'(last) + k) % NUM_DRIVES]) begin
            pick_vld = 1'b1;
            pick_idx = IDX_W'((int'(last) + k) % NUM_DRIVES);
         end
      end
   end

   always_comb begin
      grant_oh = '0;
      for (int i = 0; i < NUM_DRIVES; i++) begin
         grant_oh[i] = (int'(grant) == i);
      end
   end

   // The counter holds the number of completed REQ cycles, so the request
   // stays up for exactly TIMEOUT cycles before being withdrawn.
   assign tmo_hit = (TIMEOUT != 24'd0) && (tmo_cnt == TIMEOUT - 24'd1);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         grant    <= '0;
         last     <= IDX_W'(NUM_DRIVES - 1);
         op_wr    <= 1'b0;
         sd_lba   <= '0;
         tmo_cnt  <= '0;
         drv_done <= '0;
         drv_err  <= '0;
      end else begin
         drv_done <= '0;
         drv_err  <= '0;
         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  grant   <= pick_idx;
                  op_wr   <= drv_wr[pick_idx];
                  sd_lba  <= drv_lba[int'(pick_idx)*LBA_W +: LBA_W];
                  tmo_cnt <= '0;
                  state   <= ST_REQ;
               end
            end
            ST_REQ: begin
               // An ack arriving on the timeout cycle still wins.
               if (sd_ack) begin
                  state <= ST_XFER;
               end else if (tmo_hit) begin
                  drv_err <= grant_oh;
                  last    <= grant;
                  state   <= ST_IDLE;
               end else if (tmo_cnt != 24'hFF_FFFF) begin
                  tmo_cnt <= tmo_cnt + 24'd1;
               end
            end
            ST_XFER: begin
               if (!sd_ack) begin
                  drv_done <= grant_oh;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               last  <= grant;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_req  = (state == ST_REQ);
   assign in_xfer = (state == ST_XFER);

   assign sd_rd       = (in_req && !op_wr)          ? grant_oh : '0;
   assign sd_wr       = (in_req &&  op_wr)          ? grant_oh : '0;
   assign drv_ack     = in_xfer                     ? grant_oh : '0;
   // Zero-latency strobe steering; strobes outside XFER are dropped.
   assign drv_buff_wr = (in_xfer && sd_dout_strobe) ? grant_oh : '0;
   assign sd_din      = in_xfer ? drv_din[int'(grant)*8 +: 8] : 8'h00;
   assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_sd_image_arbiter.sv
`timescale 1ns/1ps
module tb_sd_image_arbiter;

   localparam int TMO = 100;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic [63:0] drv_lba = '0;
   logic [1:0]  drv_rd = '0;
   logic [1:0]  drv_wr = '0;
   logic [15:0] drv_din = '0;
   logic [1:0]  drv_ack, drv_buff_wr, drv_done, drv_err, sd_rd, sd_wr;
   logic [31:0] sd_lba;
   logic        sd_ack = 1'b0;
   logic [8:0]  sd_buff_addr = '0;
   logic        sd_dout_strobe = 1'b0;
   logic [7:0]  sd_din;
   logic        busy;

   sd_image_arbiter #(.NUM_DRIVES(2), .LBA_W(32), .TIMEOUT(24'd100)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .drv_lba(drv_lba), .drv_rd(drv_rd),
      .drv_wr(drv_wr), .drv_din(drv_din), .drv_ack(drv_ack),
      .drv_buff_wr(drv_buff_wr), .drv_done(drv_done), .drv_err(drv_err),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .sd_buff_addr(sd_buff_addr), .sd_dout_strobe(sd_dout_strobe),
      .sd_din(sd_din), .busy(busy));

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (transaction level) ----------------
   logic [1:0]  e_rd = '0, e_wr = '0, e_ack = '0, e_done = '0, e_err = '0;
   logic [31:0] e_lba = '0;
   logic        e_busy = 1'b0;
   int          m_last = 1;

   function automatic int rr_pick(input int lst, input logic [1:0] pend);
      for (int k = 1; k <= 2; k++)
         if (pend[(lst + k) % 2]) return (lst + k) % 2;
      return -1;
   endfunction

   task automatic m_idle();
      e_rd = '0; e_wr = '0; e_ack = '0; e_done = '0; e_err = '0;
      e_lba = '0; e_busy = 1'b0; m_last = 1;
   endtask

   task automatic tick(output bit rs);
      @(posedge clk_sys or negedge reset_n);
      rs = !reset_n;
      if (rs) m_idle();
   endtask

   initial begin : model
      bit rs;
      int g, cnt;
      bit wrop;
      logic [1:0] pend;
      forever begin
         tick(rs);
         if (rs) continue;
         e_done = '0; e_err = '0;
         pend = drv_rd | drv_wr;
         if (pend == 2'b00) continue;
         g = rr_pick(m_last, pend);
         wrop = drv_wr[g];
         e_lba = drv_lba[g*32 +: 32];
         e_busy = 1'b1;
         if (wrop) e_wr[g] = 1'b1; else e_rd[g] = 1'b1;
         cnt = 0;
         forever begin
            tick(rs);
            if (rs || sd_ack) break;
            cnt++;
            if (cnt == TMO) break;
         end
         if (rs) continue;
         e_rd = '0; e_wr = '0;
         if (!sd_ack) begin
            e_err[g] = 1'b1; e_busy = 1'b0; m_last = g;
            continue;
         end
         e_ack[g] = 1'b1;
         forever begin
            tick(rs);
            if (rs || !sd_ack) break;
         end
         if (rs) continue;
         e_ack = '0; e_done[g] = 1'b1;
         tick(rs);
         if (rs) continue;
         e_done = '0; e_busy = 1'b0; m_last = g;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk_sys) begin
      chk("sd_rd", sd_rd, e_rd);
      chk("sd_wr", sd_wr, e_wr);
      chk("drv_ack", drv_ack, e_ack);
      chk("drv_done", drv_done, e_done);
      chk("drv_err", drv_err, e_err);
      chk("sd_lba", sd_lba, e_lba);
      chk("busy", busy, e_busy);
      chk("drv_buff_wr", drv_buff_wr, e_ack & {2{sd_dout_strobe}});
      chk("sd_din", sd_din, e_ack[0] ? drv_din[7:0] : (e_ack[1] ? drv_din[15:8] : 8'h00));
      chk("ack_onehot", ($countones(drv_ack) <= 1), 1'b1);
   end

   // ---------------- pulse counters ----------------
   int n_bw0 = 0, n_bw1 = 0, n_done0 = 0, n_done1 = 0, n_err0 = 0, n_err1 = 0;
   always @(negedge clk_sys) begin
      if (drv_buff_wr[0]) n_bw0++;
      if (drv_buff_wr[1]) n_bw1++;
      if (drv_done[0]) n_done0++;
      if (drv_done[1]) n_done1++;
      if (drv_err[0]) n_err0++;
      if (drv_err[1]) n_err1++;
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk_sys);
      #2;
   endtask

   task automatic serve(input int nstb, input bit drop, output int gi);
      int n;
      n = 0;
      while ((sd_rd | sd_wr) == 2'b00 && n < 50) begin n++; cyc(1); end
      chk("grant_wait", (n < 50), 1'b1);
      gi = (sd_rd[1] | sd_wr[1]) ? 1 : 0;
      if (drop) begin drv_rd = '0; drv_wr = '0; end
      sd_ack = 1'b1;
      cyc(1);
      for (int i = 0; i < nstb; i++) begin
         sd_dout_strobe = 1'b1; cyc(1);
         sd_dout_strobe = 1'b0; cyc(1);
      end
      sd_ack = 1'b0;
      cyc(1);
      n = 0;
      while (busy && n < 10) begin n++; cyc(1); end
      chk("idle_wait", (n < 10), 1'b1);
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0; cyc(2);
      reset_n = 1'b1; cyc(1);
   endtask

   int gi, s_bw0, s_bw1, s_d0, s_d1, s_e0, s_e1, n;

   initial begin
      cyc(3);
      chk("rst_busy", busy, 1'b0);
      chk("rst_lba", sd_lba, 32'h0);
      reset_n = 1'b1;
      cyc(1);

      // Single read on drive 0
      s_bw0 = n_bw0; s_bw1 = n_bw1; s_d0 = n_done0; s_d1 = n_done1;
      drv_lba[31:0] = 32'h12; drv_rd = 2'b01;
      cyc(1);
      chk("t1_sd_rd", sd_rd, 2'b01);
      chk("t1_sd_lba", sd_lba, 32'h12);
      serve(512, 1'b1, gi);
      chk("t1_grant", gi, 0);
      chk("t1_bw0", n_bw0 - s_bw0, 512);
      chk("t1_bw1", n_bw1 - s_bw1, 0);
      chk("t1_done0", n_done0 - s_d0, 1);
      chk("t1_done1", n_done1 - s_d1, 0);

      // Contention, fresh round-robin pointer
      pulse_reset();
      s_d0 = n_done0; s_d1 = n_done1;
      drv_lba = {32'h200, 32'h100}; drv_rd = 2'b11;
      for (int i = 0; i < 4; i++) begin
         serve(4, (i == 3), gi);
         chk("t2_order", gi, i % 2);
      end
      chk("t2_done0", n_done0 - s_d0, 2);
      chk("t2_done1", n_done1 - s_d1, 2);

      // Write path, drive 1
      drv_din = {8'hA5, 8'h3C}; drv_wr = 2'b10;
      cyc(1);
      chk("t3_sd_wr", sd_wr, 2'b10);
      chk("t3_sd_rd", sd_rd, 2'b00);
      chk("t3_din_req", sd_din, 8'h00);
      drv_wr = 2'b00; sd_ack = 1'b1;
      cyc(1);
      chk("t3_din_xfer", sd_din, 8'hA5);
      cyc(2);
      chk("t3_din_xfer2", sd_din, 8'hA5);
      sd_ack = 1'b0;
      cyc(1);
      chk("t3_din_done", sd_din, 8'h00);
      cyc(2);
      // rd+wr together on drive 0: write wins
      drv_rd = 2'b01; drv_wr = 2'b01;
      cyc(1);
      chk("t3_both_wr", sd_wr, 2'b01);
      chk("t3_both_rd", sd_rd, 2'b00);
      serve(2, 1'b1, gi);
      chk("t3_both_grant", gi, 0);

      // Timeout
      s_d0 = n_done0; s_e0 = n_err0; s_e1 = n_err1;
      drv_rd = 2'b01;
      cyc(1);
      drv_rd = 2'b00;
      n = 0;
      while (sd_rd != 2'b00 && n < 300) begin n++; cyc(1); end
      chk("t4_req_cycles", n, TMO);
      chk("t4_err_now", drv_err, 2'b01);
      chk("t4_busy", busy, 1'b0);
      cyc(1);
      chk("t4_err_gone", drv_err, 2'b00);
      chk("t4_err0", n_err0 - s_e0, 1);
      chk("t4_err1", n_err1 - s_e1, 0);
      chk("t4_done0", n_done0 - s_d0, 0);

      // Latching of LBA and grant
      s_d0 = n_done0;
      drv_lba[31:0] = 32'h55; drv_rd = 2'b01;
      cyc(1);
      drv_lba[31:0] = 32'hAA; drv_rd = 2'b00;
      cyc(2);
      chk("t5_lba_req", sd_lba, 32'h55);
      chk("t5_rd_held", sd_rd, 2'b01);
      serve(3, 1'b0, gi);
      chk("t5_done0", n_done0 - s_d0, 1);
      chk("t5_lba_after", sd_lba, 32'h55);

      // Reset in the middle of a transfer
      s_d0 = n_done0; s_d1 = n_done1; s_e0 = n_err0; s_e1 = n_err1;
      drv_lba[31:0] = 32'h77; drv_rd = 2'b01;
      cyc(1);
      drv_rd = 2'b00; sd_ack = 1'b1;
      cyc(1);
      for (int i = 0; i < 100; i++) begin
         sd_dout_strobe = 1'b1; cyc(1);
         sd_dout_strobe = 1'b0; cyc(1);
      end
      sd_dout_strobe = 1'b1;
      reset_n = 1'b0;
      #1;
      chk("t6_ack", drv_ack, 2'b00);
      chk("t6_bw", drv_buff_wr, 2'b00);
      chk("t6_din", sd_din, 8'h00);
      chk("t6_busy", busy, 1'b0);
      chk("t6_lba", sd_lba, 32'h0);
      chk("t6_req", sd_rd | sd_wr, 2'b00);
      cyc(1);
      sd_ack = 1'b0; sd_dout_strobe = 1'b0;
      cyc(1);
      reset_n = 1'b1; drv_rd = 2'b11;
      cyc(1);
      chk("t6_first_grant", sd_rd, 2'b01);
      serve(2, 1'b1, gi);
      chk("t6_grant", gi, 0);
      chk("t6_done0", n_done0 - s_d0, 1);
      chk("t6_done1", n_done1 - s_d1, 0);
      chk("t6_err", (n_err0 - s_e0) + (n_err1 - s_e1), 0);
      cyc(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
